altera_up_fifo_serial_transmitter: RTL and testbench

- Serial (RS232-style) transmit stage that sits directly downstream of the team's show-ahead synchronous FIFO.
- Pops one word at a time from the FIFO and shifts it out as a frame: start bit, data LSB-first, optional even parity, stop bit.
- Used by the UART and serial-debug cores. The CPU side writes the FIFO; this block drains it onto the line.

---
 rtl/altera_up_fifo_serial_transmitter.sv | 122 ++++++++++++
 tb/tb_altera_up_fifo_serial_transmitter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/altera_up_fifo_serial_transmitter.sv
// Serial line transmitter draining a show-ahead FIFO: start bit, data LSB-first,
// optional even parity, stop bit. Pops one word per frame, back-to-back when possible.
module altera_up_fifo_serial_transmitter #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 434,
    parameter int CNT_WIDTH      = 9,
    parameter int PARITY_EN      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  transmit_enable,
    input  logic                  fifo_is_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_en,
    output logic                  serial_data_out,
    output logic                  transmitting,
    output logic [15:0]           frames_sent
);

    localparam int N_BITS = DATA_WIDTH + 2 + PARITY_EN;
    localparam int IDX_W  = $clog2(N_BITS);
    localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(N_BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  baud_q, baud_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N_BITS-2:0]     shift_q, shift_d;
    logic                  line_q, line_d;
    logic [15:0]           sent_q, sent_d;
    logic                  last_cycle;
    logic                  pop;
    logic [N_BITS-2:0]     tail;

    // Everything after the start bit, in line order: data, parity (if enabled), stop.
    function automatic logic [N_BITS-2:0] build_tail(input logic [DATA_WIDTH-1:0] d);
        logic [N_BITS-2:0] f;
        f = '1;
        f[DATA_WIDTH-1:0] = d;
        if (PARITY_EN != 0) f[DATA_WIDTH] = ^d;
        return f;
    endfunction

    assign last_cycle = (state_q == SHIFT) && (baud_q == BAUD_LAST) && (idx_q == IDX_LAST);
    assign pop  = ((state_q == IDLE) || last_cycle) && transmit_enable && !fifo_is_empty && !reset;
    assign tail = build_tail(fifo_read_data);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        line_d  = line_q;
        sent_d  = sent_q;
        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (pop) begin
                    state_d = SHIFT;
                    baud_d  = '0;
                    idx_d   = '0;
                    line_d  = 1'b0;
                    shift_d = tail;
                end
            end
            SHIFT: begin
                if (last_cycle) begin
                    sent_d = sent_q + 16'd1;
                    baud_d = '0;
                    idx_d  = '0;
                    if (pop) begin
                        line_d  = 1'b0;
                        shift_d = tail;
                    end else begin
                        state_d = IDLE;
                        line_d  = 1'b1;
                    end
                end else if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    line_d  = shift_q[0];
                    shift_d = {1'b1, shift_q[N_BITS-2:1]};
                end else begin
                    baud_d = baud_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            line_q  <= 1'b1;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            sent_q  <= sent_d;
        end
    end

    // Frame payload is only meaningful in SHIFT, so it carries no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign fifo_read_en    = pop;
    assign serial_data_out = line_q;
    assign transmitting    = (state_q == SHIFT);
    assign frames_sent     = sent_q;

endmodule

// File: tb/tb_altera_up_fifo_serial_transmitter.sv
// Directed bench: two transmitters (parity off / on, 4 clocks per bit) each fed by a small FIFO model.
module tb_altera_up_fifo_serial_transmitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  mem0 [16];
    logic [7:0]  mem1 [16];
    logic [3:0]  wr0 = '0, rd0 = '0, wr1 = '0, rd1 = '0;
    logic        empty0, empty1, rden0, rden1, line0, line1, tr0, tr1;
    logic [15:0] fs0, fs1;
    logic [7:0]  rdata0, rdata1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign empty0 = (wr0 == rd0);
    assign empty1 = (wr1 == rd1);
    assign rdata0 = mem0[rd0];
    assign rdata1 = mem1[rd1];

    always @(posedge clk) begin
        if (rden0) rd0 <= rd0 + 4'd1;
        if (rden1) rd1 <= rd1 + 4'd1;
    end

    altera_up_fifo_serial_transmitter #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(4), .CNT_WIDTH(9), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset(reset), .transmit_enable(en), .fifo_is_empty(empty0),
        .fifo_read_data(rdata0), .fifo_read_en(rden0), .serial_data_out(line0),
        .transmitting(tr0), .frames_sent(fs0));

    altera_up_fifo_serial_transmitter #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(4), .CNT_WIDTH(9), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset(reset), .transmit_enable(en), .fifo_is_empty(empty1),
        .fifo_read_data(rdata1), .fifo_read_en(rden1), .serial_data_out(line1),
        .transmitting(tr1), .frames_sent(fs1));

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [10:0] exp;
        int         nbits;
        bit         next_pop;
        int         fs_before;
        int         fs_after;
    } vec_t;

    vec_t tbl [5];

    function automatic logic get_line(input int s); return (s == 0) ? line0 : line1; endfunction
    function automatic logic get_tr(input int s);   return (s == 0) ? tr0 : tr1;     endfunction
    function automatic logic get_rd(input int s);   return (s == 0) ? rden0 : rden1; endfunction
    function automatic logic [15:0] get_fs(input int s); return (s == 0) ? fs0 : fs1; endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d);
        if (s == 0) begin
            mem0[wr0] = d;
            wr0 = wr0 + 4'd1;
        end else begin
            mem1[wr1] = d;
            wr1 = wr1 + 4'd1;
        end
    endtask

    // Expects the pop strobe in the current cycle (called just after a negedge).
    task automatic wait_pop(input int s);
        int i;
        #1;
        for (i = 0; i < 200; i++) begin
            if (get_rd(s)) break;
            @(negedge clk);
            #1;
        end
        chk("pop_latency", i, 0);
    endtask

    task automatic check_frame(input int s, input logic [10:0] exp, input int nbits,
                               input bit next_pop, input int fs_before);
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) chk("frames_sent_at_start", get_fs(s), fs_before);
                chk("line_bit", get_line(s), exp[k]);
                chk("transmitting", get_tr(s), 1);
                chk("read_en", get_rd(s), (k == nbits - 1 && c == 3) ? next_pop : 1'b0);
            end
        end
    endtask

    task automatic check_idle(input int s, input int fs);
        @(negedge clk);
        chk("idle_transmitting", get_tr(s), 0);
        chk("idle_line", get_line(s), 1);
        chk("idle_read_en", get_rd(s), 0);
        chk("frames_sent", get_fs(s), fs);
    endtask

    initial begin
        logic [10:0] exp11;
        logic [3:0]  ptr;
        bit          bad;

        tbl[0] = '{0, 8'h55, 11'h2AA, 10, 1'b0, 0, 1};
        tbl[1] = '{0, 8'hA3, 11'h346, 10, 1'b1, 1, 2};
        tbl[2] = '{0, 8'h0F, 11'h21E, 10, 1'b0, 2, 3};
        tbl[3] = '{1, 8'h07, 11'h60E, 11, 1'b0, 0, 1};
        tbl[4] = '{1, 8'h03, 11'h406, 11, 1'b0, 1, 2};

        repeat (3) @(negedge clk);
        chk("reset_line0", line0, 1);
        chk("reset_line1", line1, 1);
        chk("reset_tr0", tr0, 0);
        chk("reset_rden0", rden0, 0);
        chk("reset_fs0", fs0, 0);
        chk("reset_fs1", fs1, 0);
        reset = 1'b0;
        en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (i == 0 || !tbl[i-1].next_pop) begin
                push(tbl[i].sel, tbl[i].data);
                if (tbl[i].next_pop) push(tbl[i+1].sel, tbl[i+1].data);
                wait_pop(tbl[i].sel);
            end
            check_frame(tbl[i].sel, tbl[i].exp, tbl[i].nbits, tbl[i].next_pop, tbl[i].fs_before);
            if (!tbl[i].next_pop) check_idle(tbl[i].sel, tbl[i].fs_after);
        end

        // Enabled but empty: no pops, line idle.
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rden0 || rden1 || !line0 || !line1 || tr0) bad = 1'b1;
        end
        chk("empty_no_pop", bad, 0);
        push(0, 8'hC8);
        wait_pop(0);
        check_frame(0, 11'h390, 10, 1'b0, 3);
        check_idle(0, 4);

        // Enable dropped mid-frame with 3 words queued.
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        wait_pop(0);
        exp11 = 11'h222;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            chk("drop_line", line0, exp11[(cyc-1)/4]);
            chk("drop_read_en", rden0, 0);
            if (cyc == 10) en = 1'b0;
        end
        check_idle(0, 5);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rden0 || tr0) bad = 1'b1;
        end
        chk("disabled_no_pop", bad, 0);
        chk("fifo_left", 32'(wr0 - rd0), 2);
        en = 1'b1;
        wait_pop(0);
        check_frame(0, 11'h244, 10, 1'b1, 5);
        check_frame(0, 11'h266, 10, 1'b0, 6);
        check_idle(0, 7);

        // Asynchronous reset mid-frame.
        push(0, 8'h44);
        push(0, 8'h66);
        wait_pop(0);
        repeat (17) @(negedge clk);
        chk("pre_reset_tr", tr0, 1);
        reset = 1'b1;
        #1;
        chk("async_reset_line", line0, 1);
        chk("async_reset_tr", tr0, 0);
        chk("async_reset_rden", rden0, 0);
        ptr = rd0;
        repeat (3) @(negedge clk);
        chk("reset_no_pop", rd0, ptr);
        chk("reset_fs", fs0, 0);
        chk("reset_fifo_left", 32'(wr0 - rd0), 1);
        reset = 1'b0;
        wait_pop(0);
        check_frame(0, 11'h2CC, 10, 1'b0, 0);
        check_idle(0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
